// File: rtl/serial_subtractor.sv
// Bit-serial two's-complement subtractor: A - B one bit per clock, LSB first,
// using one full-subtractor cell and a borrow flop behind a start/done handshake.
module serial_subtractor #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout
);
    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] ra_q, ra_d;
    logic [WIDTH-1:0] rb_q, rb_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             br_q, br_d;
    logic             bout_q, bout_d;
    logic             bit_d;
    logic             br_next;

    // Full-subtractor cell on the current LSBs.
    assign bit_d   = ra_q[0] ^ rb_q[0] ^ br_q;
    assign br_next = (~ra_q[0] & rb_q[0]) | (~(ra_q[0] ^ rb_q[0]) & br_q);

    always_comb begin
        state_d = state_q;
        ra_d    = ra_q;
        rb_d    = rb_q;
        diff_d  = diff_q;
        cnt_d   = cnt_q;
        br_d    = br_q;
        bout_d  = bout_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    ra_d    = a;
                    rb_d    = b;
                    br_d    = 1'b0;
                    cnt_d   = '0;
                    diff_d  = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                ra_d   = {1'b0, ra_q[WIDTH-1:1]};
                rb_d   = {1'b0, rb_q[WIDTH-1:1]};
                // Result bits enter at the MSB so bit 0 lands in diff[0] after WIDTH shifts.
                diff_d = {bit_d, diff_q[WIDTH-1:1]};
                br_d   = br_next;
                cnt_d  = cnt_q + CW'(1);
                if (cnt_q == CW'(WIDTH - 1)) begin
                    bout_d  = br_next;
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            ra_q    <= '0;
            rb_q    <= '0;
            diff_q  <= '0;
            cnt_q   <= '0;
            br_q    <= 1'b0;
            bout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ra_q    <= ra_d;
            rb_q    <= rb_d;
            diff_q  <= diff_d;
            cnt_q   <= cnt_d;
            br_q    <= br_d;
            bout_q  <= bout_d;
        end
    end

    assign ready = (state_q == IDLE);
    assign busy  = (state_q == RUN);
    assign done  = (state_q == DONE);
    assign diff  = diff_q;
    assign bout  = bout_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor: a cycle model tracks the handshake phase,
// expected results are queued on acceptance and compared when done pulses.
module tb_serial_subtractor;
    localparam int WIDTH = 4;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             start = 1'b0;
    logic [WIDTH-1:0] a = '0;
    logic [WIDTH-1:0] b = '0;
    logic             ready, busy, done, bout;
    logic [WIDTH-1:0] diff;

    serial_subtractor #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .ready (ready),
        .busy  (busy),
        .done  (done),
        .diff  (diff),
        .bout  (bout)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h at %0t", tag, act, exp, $time);
        end
    endtask

    // Reference model: phase 0 = idle, 1..WIDTH = running, WIDTH+1 = done cycle.
    logic [WIDTH:0]   sb[$];
    int               m_phase = 0;
    int               accepts = 0;
    int               armed   = 0;
    logic [WIDTH-1:0] m_diff  = '0;
    logic             m_bout  = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            m_phase = 0;
            m_diff  = '0;
            m_bout  = 1'b0;
            sb.delete();
            armed   = 1;
        end else if (armed != 0) begin
            if (m_phase == 0) begin
                if (start) begin
                    sb.push_back({(a < b), WIDTH'(a - b)});
                    accepts++;
                    m_phase = 1;
                end
            end else if (m_phase == WIDTH + 1) begin
                m_phase = 0;
            end else begin
                m_phase = m_phase + 1;
            end
        end
    end

    always @(negedge clk) begin
        logic [WIDTH:0] e;
        if (armed != 0) begin
            chk("ready", 32'(ready), 32'(m_phase == 0));
            chk("busy",  32'(busy),  32'(m_phase >= 1 && m_phase <= WIDTH));
            chk("done",  32'(done),  32'(m_phase == WIDTH + 1));
            if (m_phase == WIDTH + 1) begin
                if (sb.size() == 0) begin
                    chk("sb_empty", 32'(1), 32'(0));
                end else begin
                    e = sb.pop_front();
                    chk("diff", 32'(diff), 32'(e[WIDTH-1:0]));
                    chk("bout", 32'(bout), 32'(e[WIDTH]));
                    m_diff = e[WIDTH-1:0];
                    m_bout = e[WIDTH];
                end
            end else begin
                if (m_phase == 0) chk("diff_hold", 32'(diff), 32'(m_diff));
                chk("bout_hold", 32'(bout), 32'(m_bout));
            end
        end
    end

    task automatic wait_idle();
        bit ok = 0;
        for (int i = 0; i < 50; i++) begin
            if (m_phase == 0) begin
                ok = 1;
                break;
            end
            @(posedge clk); #1;
        end
        if (!ok) chk("timeout_idle", 32'(1), 32'(0));
    endtask

    task automatic op(input logic [WIDTH-1:0] ia, input logic [WIDTH-1:0] ib);
        a = ia; b = ib; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        a = WIDTH'($urandom_range(15));
        b = WIDTH'($urandom_range(15));
        wait_idle();
        $display("op a=%0d b=%0d -> diff=%0d bout=%0d", ia, ib, diff, bout);
    endtask

    initial begin
        int c;
        bit ok;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk); #1;

        op(4'd9, 4'd3);
        op(4'd3, 4'd9);
        op(4'd0, 4'd1);
        op(4'd15, 4'd15);

        // Back-to-back sweep with start held high.
        start = 1'b1;
        for (int i = 0; i < 256; i++) begin
            a = WIDTH'(i >> 4);
            b = WIDTH'(i & 15);
            c = accepts;
            ok = 0;
            for (int k = 0; k < 20; k++) begin
                @(posedge clk); #1;
                if (accepts != c) begin
                    ok = 1;
                    break;
                end
            end
            if (!ok) chk("timeout_accept", 32'(1), 32'(0));
        end
        start = 1'b0;
        wait_idle();
        $display("sweep of 256 pairs complete");

        // Stray starts during RUN and DONE must be ignored.
        a = 4'd5; b = 4'd2; start = 1'b1;
        @(posedge clk); #1;
        for (int k = 0; k < 20; k++) begin
            if (m_phase == 0) break;
            start = 1'b1;
            a = WIDTH'($urandom_range(15));
            b = WIDTH'($urandom_range(15));
            @(posedge clk); #1;
        end
        start = 1'b0;
        wait_idle();
        $display("stray-start op a=5 b=2 -> diff=%0d bout=%0d", diff, bout);

        // Reset during the second RUN cycle, then a fresh operation.
        a = 4'd12; b = 4'd5; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        $display("mid-run reset -> ready=%0d diff=%0d bout=%0d", ready, diff, bout);
        op(4'd7, 4'd2);

        // Idle hold: outputs must stay put for 10 cycles.
        repeat (10) @(posedge clk);
        #1;
        $display("hold -> diff=%0d bout=%0d ready=%0d", diff, bout, ready);

        chk("sb_drained", 32'(sb.size()), 32'(0));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
